// File: rtl/rx_txn_ctrl.sv
// Host transaction sequencer: waits for the decoded response, checks PID and the DATA0/1 toggle, ACKs, retries.
// Decision lands 1 cycle after pktOutAvail; hs_req holds until hs_ack, and no other input is ever stalled.
module rx_txn_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8,
  parameter int TW        = 8
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        txn_start,
  input  logic        txn_is_in,
  input  logic [98:0] pkt,
  input  logic        pktOutAvail,
  input  logic        valid,
  output logic        hs_req,
  output logic [3:0]  hs_pid,
  input  logic        hs_ack,
  output logic        retry,
  output logic [63:0] data_out,
  output logic        data_valid,
  output logic        txn_done,
  output logic        txn_ok,
  output logic        busy,
  output logic [3:0]  retry_cnt
);
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [2:0] {IDLE, WAIT_RESP, SEND_HS, RETRY, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cnt_d;
  logic          toggle_q, toggle_d;
  logic          is_in_q, is_in_d;
  logic          ok_d, dv_d;
  logic [63:0]   data_d;
  logic [3:0]    data_pid, hand_pid, exp_pid, dup_pid;
  logic          unused_pkt_bits;

  assign data_pid = pkt[90:87];
  assign hand_pid = pkt[10:7];
  assign exp_pid  = toggle_q ? PID_DATA1 : PID_DATA0;
  assign dup_pid  = toggle_q ? PID_DATA0 : PID_DATA1;
  assign unused_pkt_bits = ^{pkt[98:91], pkt[86:83], pkt[18:11], pkt[6:0]};

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = retry_cnt;
    toggle_d = toggle_q;
    is_in_d  = is_in_q;
    ok_d     = txn_ok;
    dv_d     = 1'b0;
    data_d   = data_out;
    case (state_q)
      IDLE: begin
        if (txn_start) begin
          is_in_d = txn_is_in;
          cnt_d   = '0;
          timer_d = '0;
          ok_d    = 1'b0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // a packet arriving on the final timer cycle still takes priority
        if (pktOutAvail) begin
          if (is_in_q) begin
            if (valid && data_pid == exp_pid) begin
              data_d   = pkt[82:19];
              dv_d     = 1'b1;
              toggle_d = ~toggle_q;
              state_d  = SEND_HS;
            end else if (valid && data_pid == dup_pid) begin
              state_d = SEND_HS;
            end else begin
              state_d = RETRY;
            end
          end else if (valid && hand_pid == PID_ACK) begin
            ok_d    = 1'b1;
            state_d = DONE;
          end else if (valid && hand_pid == PID_STALL) begin
            ok_d    = 1'b0;
            state_d = DONE;
          end else begin
            // NAK, corrupt or unexpected handshake
            state_d = RETRY;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = RETRY;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SEND_HS: begin
        if (hs_ack) begin
          ok_d    = 1'b1;
          state_d = DONE;
        end
      end
      RETRY: begin
        if (retry_cnt == 4'(MAX_RETRY)) begin
          ok_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = retry_cnt + 4'd1;
          timer_d = '0;
          state_d = WAIT_RESP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retry_cnt  <= '0;
      toggle_q   <= 1'b0;
      is_in_q    <= 1'b0;
      txn_ok     <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_cnt  <= cnt_d;
      toggle_q   <= toggle_d;
      is_in_q    <= is_in_d;
      txn_ok     <= ok_d;
      data_valid <= dv_d;
      data_out   <= data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign hs_req   = (state_q == SEND_HS);
  assign hs_pid   = hs_req ? PID_ACK : 4'd0;
  assign retry    = (state_q == RETRY) && (retry_cnt != 4'(MAX_RETRY));
  assign txn_done = (state_q == DONE);
endmodule

// File: tb/tb_rx_txn_ctrl.sv
// Randomised transaction-level bench for rx_txn_ctrl with an attempt-by-attempt outcome model.
module tb_rx_txn_ctrl;
  localparam int TIMEOUT   = 255;
  localparam int MAX_RETRY = 8;
  localparam logic [3:0] ACK = 4'b0010, NAK = 4'b1010, STALL = 4'b1110;
  localparam logic [3:0] DATA0 = 4'b0011, DATA1 = 4'b1011;
  localparam int K_TMO = 0, K_PKT = 1;
  localparam int EV_NONE = 0, EV_RETRY = 1, EV_HS = 2, EV_DONE = 3, EV_OTHER = 4;

  logic        clk, rst_b, txn_start, txn_is_in, pktOutAvail, valid, hs_ack;
  logic        hs_req, retry, data_valid, txn_done, txn_ok, busy;
  logic [98:0] pkt;
  logic [3:0]  hs_pid, retry_cnt;
  logic [63:0] data_out;

  rx_txn_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .TW(8)) dut (
    .clk(clk), .rst_b(rst_b), .txn_start(txn_start), .txn_is_in(txn_is_in),
    .pkt(pkt), .pktOutAvail(pktOutAvail), .valid(valid),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_ack(hs_ack), .retry(retry),
    .data_out(data_out), .data_valid(data_valid), .txn_done(txn_done),
    .txn_ok(txn_ok), .busy(busy), .retry_cnt(retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail, n_dv, n_retry, n_pid_bad;
  // one transaction's scripted responses, one entry per attempt
  int          a_kind [16];
  int          a_dly  [16];
  logic        a_valid[16];
  logic [3:0]  a_pid  [16];
  logic [63:0] a_pl   [16];
  // model expectations
  int          e_evt[16], e_lat[16], e_r[16];
  int          e_n, e_cnt;
  logic        e_ok, e_dv;
  logic        m_toggle;
  logic [63:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (data_valid) n_dv++;
    if (retry) n_retry++;
    if (hs_req && hs_pid != ACK) n_pid_bad++;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [98:0] mk_pkt(input logic is_in, input logic [3:0] pid, input logic [63:0] pl);
    logic [98:0] p;
    p = {3'($urandom), $urandom, $urandom, $urandom};
    p[98:91] = 8'h80;
    p[82:19] = pl;
    if (is_in) p[90:87] = pid;
    else       p[10:7]  = pid;
    return p;
  endfunction

  task automatic set_att(input int a, input int kind, input logic v, input logic [3:0] pid, input int dly);
    a_kind[a] = kind; a_valid[a] = v; a_pid[a] = pid; a_dly[a] = dly; a_pl[a] = rand64();
  endtask

  task automatic gen_rand();
    int sel;
    for (int a = 0; a < 16; a++) begin
      a_kind[a]  = ($urandom_range(0, 15) == 0) ? K_TMO : K_PKT;
      a_dly[a]   = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 12);
      a_valid[a] = ($urandom_range(0, 3) != 0);
      a_pl[a]    = rand64();
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a_pid[a] = DATA0;
        1:       a_pid[a] = DATA1;
        2:       a_pid[a] = ACK;
        3:       a_pid[a] = NAK;
        4:       a_pid[a] = STALL;
        default: a_pid[a] = 4'($urandom);
      endcase
    end
  endtask

  // Walk the attempts by the protocol rules: what each attempt leads to and when.
  task automatic model(input logic is_in);
    int r;
    bit fin, good;
    logic [3:0] want, dup;
    r = 0; fin = 0; e_dv = 0; e_ok = 0; e_n = 0;
    for (int a = 0; a < 16 && !fin; a++) begin
      good = 0;
      e_lat[a] = (a_kind[a] == K_TMO) ? TIMEOUT : a_dly[a] + 1;
      want = m_toggle ? DATA1 : DATA0;
      dup  = m_toggle ? DATA0 : DATA1;
      if (a_kind[a] == K_PKT && a_valid[a]) begin
        if (is_in && a_pid[a] == want) begin
          good = 1; e_dv = 1; e_ok = 1; e_evt[a] = EV_HS;
          m_toggle = ~m_toggle; m_data = a_pl[a];
        end else if (is_in && a_pid[a] == dup) begin
          good = 1; e_ok = 1; e_evt[a] = EV_HS;
        end else if (!is_in && a_pid[a] == ACK) begin
          good = 1; e_ok = 1; e_evt[a] = EV_DONE;
        end else if (!is_in && a_pid[a] == STALL) begin
          good = 1; e_ok = 0; e_evt[a] = EV_DONE;
        end
      end
      if (good) fin = 1;
      else if (r == MAX_RETRY) begin
        e_evt[a] = EV_DONE; e_lat[a]++; e_ok = 0; fin = 1;
      end else begin
        r++; e_evt[a] = EV_RETRY;
      end
      e_r[a] = r;
      e_n = a + 1;
    end
    e_cnt = r;
  endtask

  task automatic reset_dut();
    rst_b = 1'b0; txn_start = 1'b0; pktOutAvail = 1'b0; valid = 1'b0; hs_ack = 1'b0;
    tick(); tick();
    rst_b = 1'b1; m_toggle = 1'b0; m_data = '0;
  endtask

  task automatic run_txn(input logic is_in);
    int evt, lat;
    bit abort;
    logic [3:0] want, stray;
    want  = m_toggle ? DATA1 : DATA0;
    stray = is_in ? want : ACK;
    n_dv = 0;
    pkt = mk_pkt(1'b1, want, rand64()); valid = 1'b1; pktOutAvail = 1'b1;
    tick();
    pktOutAvail = 1'b0; valid = 1'b0;
    chk("idle_pkt_dv", 64'(n_dv), 64'(0));
    model(is_in);
    n_dv = 0; n_retry = 0; n_pid_bad = 0; abort = 0;
    txn_is_in = is_in; txn_start = 1'b1;
    tick();
    txn_start = 1'b0;
    chk("busy_start", 64'(busy), 64'(1));
    for (int a = 0; a < e_n && !abort; a++) begin
      evt = EV_NONE; lat = 0;
      for (int j = 0; j < 400 && evt == EV_NONE; j++) begin
        if (a_kind[a] == K_PKT && j == a_dly[a]) begin
          pkt = mk_pkt(is_in, a_pid[a], a_pl[a]); valid = a_valid[a]; pktOutAvail = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          txn_start = 1'b1; txn_is_in = ~is_in;
        end
        tick();
        pktOutAvail = 1'b0; valid = 1'b0; txn_start = 1'b0;
        lat = j + 1;
        if (retry)           evt = EV_RETRY;
        else if (hs_req)     evt = EV_HS;
        else if (txn_done)   evt = EV_DONE;
        else if (data_valid) evt = EV_OTHER;
      end
      chk($sformatf("event_att%0d", a), 64'(evt), 64'(e_evt[a]));
      chk($sformatf("latency_att%0d", a), 64'(lat), 64'(e_lat[a]));
      if (evt != e_evt[a] || lat != e_lat[a]) begin
        abort = 1;
      end else if (evt == EV_RETRY) begin
        pkt = mk_pkt(is_in, stray, rand64()); valid = 1'b1; pktOutAvail = 1'($urandom_range(0, 1));
        tick();
        pktOutAvail = 1'b0; valid = 1'b0;
        chk("retry_cnt_step", 64'(retry_cnt), 64'(e_r[a]));
        chk("retry_one_cycle", 64'(retry), 64'(0));
      end else if (evt == EV_HS) begin
        chk("hs_data_valid", 64'(data_valid), 64'(e_dv));
        if (e_dv) chk("hs_data_out", data_out, m_data);
        repeat ($urandom_range(0, 4)) begin
          pkt = mk_pkt(is_in, a_pid[a], rand64()); valid = 1'b1; pktOutAvail = 1'($urandom_range(0, 1));
          tick();
          pktOutAvail = 1'b0; valid = 1'b0;
        end
        chk("hs_req_held", 64'(hs_req), 64'(1));
        hs_ack = 1'b1;
        tick();
        hs_ack = 1'b0;
        chk("hs_req_drop", 64'(hs_req), 64'(0));
        chk("done_after_ack", 64'(txn_done), 64'(1));
      end
    end
    if (abort) begin
      reset_dut();
    end else begin
      chk("done_pulse", 64'(txn_done), 64'(1));
      chk("txn_ok", 64'(txn_ok), 64'(e_ok));
      chk("retry_cnt_final", 64'(retry_cnt), 64'(e_cnt));
      chk("data_valid_count", 64'(n_dv), 64'(e_dv));
      chk("retry_pulse_count", 64'(n_retry), 64'(e_cnt));
      chk("hs_pid_ack", 64'(n_pid_bad), 64'(0));
      tick();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("done_one_cycle", 64'(txn_done), 64'(0));
      chk("txn_ok_held", 64'(txn_ok), 64'(e_ok));
      chk("data_out_stable", data_out, m_data);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] want;
    n_chk = 0; n_fail = 0; n_dv = 0; n_retry = 0; n_pid_bad = 0;
    rst_b = 1'b0; txn_start = 1'b0; txn_is_in = 1'b0; pkt = '0;
    pktOutAvail = 1'b0; valid = 1'b0; hs_ack = 1'b0;
    m_toggle = 1'b0; m_data = '0;
    #12;
    chk("rst_hs_req", 64'(hs_req), 64'(0));
    chk("rst_hs_pid", 64'(hs_pid), 64'(0));
    chk("rst_retry", 64'(retry), 64'(0));
    chk("rst_data_out", data_out, 64'(0));
    chk("rst_data_valid", 64'(data_valid), 64'(0));
    chk("rst_txn_done", 64'(txn_done), 64'(0));
    chk("rst_txn_ok", 64'(txn_ok), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_retry_cnt", 64'(retry_cnt), 64'(0));
    tick();
    rst_b = 1'b1;
    tick();

    set_att(0, K_PKT, 1'b1, DATA0, 9);           run_txn(1'b1);
    set_att(0, K_PKT, 1'b1, DATA0, 3);           run_txn(1'b1);
    for (int a = 0; a <= MAX_RETRY; a++) set_att(a, K_TMO, 1'b0, DATA0, 0);
    run_txn(1'b1);
    set_att(0, K_PKT, 1'b1, NAK, 2);
    set_att(1, K_PKT, 1'b1, NAK, 5);
    set_att(2, K_PKT, 1'b1, ACK, 0);             run_txn(1'b0);
    set_att(0, K_PKT, 1'b1, STALL, 4);           run_txn(1'b0);
    set_att(0, K_PKT, 1'b0, DATA1, 1);
    set_att(1, K_PKT, 1'b1, DATA1, TIMEOUT - 1); run_txn(1'b1);
    set_att(0, K_TMO, 1'b0, ACK, 0);
    set_att(1, K_PKT, 1'b1, ACK, TIMEOUT - 1);   run_txn(1'b0);

    // reset while the handshake is pending
    want = m_toggle ? DATA1 : DATA0;
    txn_is_in = 1'b1; txn_start = 1'b1;
    tick();
    txn_start = 1'b0;
    pkt = mk_pkt(1'b1, want, rand64()); valid = 1'b1; pktOutAvail = 1'b1;
    tick();
    pktOutAvail = 1'b0; valid = 1'b0;
    chk("pre_rst_hs_req", 64'(hs_req), 64'(1));
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_hs_req", 64'(hs_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_hs_pid", 64'(hs_pid), 64'(0));
    chk("mid_rst_data_valid", 64'(data_valid), 64'(0));
    chk("mid_rst_data_out", data_out, 64'(0));
    tick();
    rst_b = 1'b1; m_toggle = 1'b0; m_data = '0;
    tick();
    chk("post_rst_no_done", 64'(txn_done), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));
    set_att(0, K_PKT, 1'b1, DATA0, 0);           run_txn(1'b1);

    repeat (24) begin
      gen_rand();
      run_txn(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
